// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, the arbiter and the unified memory.
// The arbiter takes the slave view; the core and memory side take the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_abort;
  logic          i_done;
  logic [DW-1:0] i_rdata;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wstrb;
  logic            d_done;
  logic [DW-1:0]   d_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  i_req, i_addr, i_abort,
    output i_done, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_done, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport master (
    output i_req, i_addr, i_abort,
    input  i_done, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_done, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the memory stage.
// Data port has priority; a streak counter bounds how long a pending fetch can wait.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = DW / 8;
  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbStateT;

  arbStateT   stateQ, stateD;
  logic [3:0] dStreak;
  logic       abortPending;

  logic iElig, dElig;
  logic grantI, grantD;
  logic ackI, ackD;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    stateD = stateQ;
    grantI = 1'b0;
    grantD = 1'b0;
    ackI   = 1'b0;
    ackD   = 1'b0;
    // A port completing this cycle sits out so it can drop or retarget its request.
    iElig  = bus.i_req && !bus.i_abort && !bus.i_done;
    dElig  = bus.d_req && !bus.d_done;

    unique case (stateQ)
      IDLE: begin
        if (dElig && (!iElig || (dStreak < MAX_STREAK))) begin
          grantD = 1'b1;
          stateD = BUSY_D;
        end else if (iElig) begin
          grantI = 1'b1;
          stateD = BUSY_I;
        end
      end
      BUSY_I: begin
        if (bus.mem_ack) begin
          ackI   = 1'b1;
          stateD = IDLE;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack) begin
          ackD   = 1'b1;
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ        <= IDLE;
      dStreak       <= '0;
      abortPending  <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.i_done    <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
    end else begin
      stateQ     <= stateD;
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;

      if (grantD) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        bus.mem_wstrb <= bus.d_we ? bus.d_wstrb : {SW{1'b1}};
        if (!bus.i_req) begin
          dStreak <= '0;
        end else if (dStreak != MAX_STREAK) begin
          dStreak <= 4'(dStreak + 4'd1);
        end
      end

      if (grantI) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= bus.i_addr;
        bus.mem_wdata <= '0;
        bus.mem_wstrb <= {SW{1'b1}};
        dStreak       <= '0;
      end

      // An aborted fetch still runs to mem_ack; only its result is dropped.
      if (ackI) begin
        bus.mem_req  <= 1'b0;
        abortPending <= 1'b0;
        if (!abortPending && !bus.i_abort) begin
          bus.i_done  <= 1'b1;
          bus.i_rdata <= bus.mem_rdata;
        end
      end else if ((stateQ == BUSY_I) && bus.i_abort) begin
        abortPending <= 1'b1;
      end

      if (ackD) begin
        bus.mem_req <= 1'b0;
        bus.d_done  <= 1'b1;
        if (!bus.mem_we) begin
          bus.d_rdata <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus a
// hand-driven starvation sequence against a zero-wait memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rstN;
    logic        iReq;
    logic [31:0] iAddr;
    logic        iAbort;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dWstrb;
    logic        memAck;
    logic [31:0] memRdata;
    logic        eMemReq;
    logic        eMemWe;
    logic [31:0] eMemAddr;
    logic [31:0] eMemWdata;
    logic [3:0]  eMemWstrb;
    logic        eIDone;
    logic [31:0] eIRdata;
    logic        eDDone;
    logic [31:0] eDRdata;
  } vecT;

  vecT vecs[$];

  function automatic vecT mk(
    input string name, input logic rstN, input logic iReq, input logic [31:0] iAddr,
    input logic iAbort, input logic dReq, input logic dWe, input logic [31:0] dAddr,
    input logic [31:0] dWdata, input logic [3:0] dWstrb, input logic memAck,
    input logic [31:0] memRdata, input logic eMemReq, input logic eMemWe,
    input logic [31:0] eMemAddr, input logic [31:0] eMemWdata, input logic [3:0] eMemWstrb,
    input logic eIDone, input logic [31:0] eIRdata, input logic eDDone, input logic [31:0] eDRdata);
    vecT v;
    v.name = name;       v.rstN = rstN;         v.iReq = iReq;         v.iAddr = iAddr;
    v.iAbort = iAbort;   v.dReq = dReq;         v.dWe = dWe;           v.dAddr = dAddr;
    v.dWdata = dWdata;   v.dWstrb = dWstrb;     v.memAck = memAck;     v.memRdata = memRdata;
    v.eMemReq = eMemReq; v.eMemWe = eMemWe;     v.eMemAddr = eMemAddr; v.eMemWdata = eMemWdata;
    v.eMemWstrb = eMemWstrb; v.eIDone = eIDone; v.eIRdata = eIRdata;   v.eDDone = eDDone;
    v.eDRdata = eDRdata;
    return v;
  endfunction

  localparam logic [31:0] F0 = 32'h0050_0093;
  localparam logic [31:0] DL = 32'hCAFE_0001;
  localparam logic [31:0] IA = 32'h00A0_0113;
  localparam logic [31:0] BF = 32'h0BAD_F00D;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string expGrants;
    string gotGrants;
    int    iDoneCnt;
    int    dDoneCnt;
    int    bothCnt;
    logic  prevReq;
    bit    finished;

    rst_n = 1'b0;
    bus.i_req = 0; bus.i_addr = '0; bus.i_abort = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;

    //              name             rst iReq iAddr        iAb dReq dWe dAddr        dWdata        dWstrb ack rdata         | eReq eWe eAddr        eWdata        eWstrb eID eIR eDD eDR
    vecs.push_back(mk("reset",         0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk("fetch_grant",   1, 1, 32'h100,     0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h100,     32'h0,        4'hF, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk("fetch_wait1",   1, 1, 32'h100,     0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h100,     32'h0,        4'hF, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk("fetch_wait2",   1, 1, 32'h100,     0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h100,     32'h0,        4'hF, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk("fetch_ack",     1, 1, 32'h100,     0, 0, 0, 32'h0,       32'h0,        4'h0, 1, F0,           0, 0, 32'h0,       32'h0,        4'h0, 1, F0,    0, 32'h0));
    vecs.push_back(mk("fetch_idle",    1, 0, 32'h100,     0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, F0,    0, 32'h0));
    vecs.push_back(mk("both_grant_d",  1, 1, 32'h104,     0, 1, 0, 32'h2000,    32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h2000,    32'h0,        4'hF, 0, F0,    0, 32'h0));
    vecs.push_back(mk("both_d_ack",    1, 1, 32'h104,     0, 1, 0, 32'h2000,    32'h0,        4'h0, 1, DL,           0, 0, 32'h0,       32'h0,        4'h0, 0, F0,    1, DL));
    vecs.push_back(mk("both_i_grant",  1, 1, 32'h104,     0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h104,     32'h0,        4'hF, 0, F0,    0, DL));
    vecs.push_back(mk("both_i_ack",    1, 1, 32'h104,     0, 0, 0, 32'h0,       32'h0,        4'h0, 1, IA,           0, 0, 32'h0,       32'h0,        4'h0, 1, IA,    0, DL));
    vecs.push_back(mk("both_idle",     1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, IA,    0, DL));
    vecs.push_back(mk("store_grant",   1, 0, 32'h0,       0, 1, 1, 32'h3004,    32'hDEADBEEF, 4'h3, 0, 32'h0,        1, 1, 32'h3004,    32'hDEADBEEF, 4'h3, 0, IA,    0, DL));
    vecs.push_back(mk("store_wait",    1, 0, 32'h0,       0, 1, 1, 32'h3004,    32'hDEADBEEF, 4'h3, 0, 32'h0,        1, 1, 32'h3004,    32'hDEADBEEF, 4'h3, 0, IA,    0, DL));
    vecs.push_back(mk("store_ack",     1, 0, 32'h0,       0, 1, 1, 32'h3004,    32'hDEADBEEF, 4'h3, 1, 32'h11111111, 0, 0, 32'h0,       32'h0,        4'h0, 0, IA,    1, DL));
    vecs.push_back(mk("store_idle",    1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, IA,    0, DL));
    vecs.push_back(mk("abort_grant",   1, 1, 32'h200,     0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h200,     32'h0,        4'hF, 0, IA,    0, DL));
    vecs.push_back(mk("abort_busy",    1, 1, 32'h200,     1, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h200,     32'h0,        4'hF, 0, IA,    0, DL));
    vecs.push_back(mk("abort_ack",     1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0, 1, 32'h12345678, 0, 0, 32'h0,       32'h0,        4'h0, 0, IA,    0, DL));
    vecs.push_back(mk("reabort_grant", 1, 1, 32'h300,     0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h300,     32'h0,        4'hF, 0, IA,    0, DL));
    vecs.push_back(mk("reabort_ack",   1, 1, 32'h300,     0, 0, 0, 32'h0,       32'h0,        4'h0, 1, BF,           0, 0, 32'h0,       32'h0,        4'h0, 1, BF,    0, DL));
    vecs.push_back(mk("reabort_idle",  1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, BF,    0, DL));
    vecs.push_back(mk("abtack_grant",  1, 1, 32'h400,     0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h400,     32'h0,        4'hF, 0, BF,    0, DL));
    vecs.push_back(mk("abtack_same",   1, 1, 32'h400,     1, 0, 0, 32'h0,       32'h0,        4'h0, 1, 32'h55,       0, 0, 32'h0,       32'h0,        4'h0, 0, BF,    0, DL));
    vecs.push_back(mk("abtack_idle",   1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, BF,    0, DL));
    vecs.push_back(mk("refetch_grant", 1, 1, 32'h404,     0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h404,     32'h0,        4'hF, 0, BF,    0, DL));
    vecs.push_back(mk("refetch_ack",   1, 1, 32'h404,     0, 0, 0, 32'h0,       32'h0,        4'h0, 1, 32'h66,       0, 0, 32'h0,       32'h0,        4'h0, 1, 32'h66, 0, DL));
    vecs.push_back(mk("idle_abort",    1, 1, 32'h500,     1, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h66, 0, DL));
    vecs.push_back(mk("idle_quiet",    1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h66, 0, DL));
    vecs.push_back(mk("rst_d_grant",   1, 0, 32'h0,       0, 1, 0, 32'h2040,    32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h2040,    32'h0,        4'hF, 0, 32'h66, 0, DL));
    vecs.push_back(mk("rst_mid_d",     0, 0, 32'h0,       0, 1, 0, 32'h2040,    32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk("rst_late_ack",  1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0, 1, 32'h99,       0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0, 0, 32'h0));
    vecs.push_back(mk("rst_after",     1, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,       32'h0,        4'h0, 0, 32'h0, 0, 32'h0));

    foreach (vecs[k]) begin
      @(negedge clk);
      rst_n         = vecs[k].rstN;
      bus.i_req     = vecs[k].iReq;
      bus.i_addr    = vecs[k].iAddr;
      bus.i_abort   = vecs[k].iAbort;
      bus.d_req     = vecs[k].dReq;
      bus.d_we      = vecs[k].dWe;
      bus.d_addr    = vecs[k].dAddr;
      bus.d_wdata   = vecs[k].dWdata;
      bus.d_wstrb   = vecs[k].dWstrb;
      bus.mem_ack   = vecs[k].memAck;
      bus.mem_rdata = vecs[k].memRdata;
      @(posedge clk);
      #1;
      check({vecs[k].name, ".mem_req"}, 32'(bus.mem_req), 32'(vecs[k].eMemReq));
      check({vecs[k].name, ".i_done"},  32'(bus.i_done),  32'(vecs[k].eIDone));
      check({vecs[k].name, ".i_rdata"}, bus.i_rdata,      vecs[k].eIRdata);
      check({vecs[k].name, ".d_done"},  32'(bus.d_done),  32'(vecs[k].eDDone));
      check({vecs[k].name, ".d_rdata"}, bus.d_rdata,      vecs[k].eDRdata);
      // Request attributes only matter while a request is up (and must be zero in reset).
      if (vecs[k].eMemReq || !vecs[k].rstN) begin
        check({vecs[k].name, ".mem_we"},    32'(bus.mem_we),    32'(vecs[k].eMemWe));
        check({vecs[k].name, ".mem_addr"},  bus.mem_addr,       vecs[k].eMemAddr);
        check({vecs[k].name, ".mem_wdata"}, bus.mem_wdata,      vecs[k].eMemWdata);
        check({vecs[k].name, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(vecs[k].eMemWstrb));
      end
    end

    // Starvation: both ports held, zero-wait memory. i_abort is raised in each
    // d_done cycle so the fetch cannot slip in there and both contend next cycle.
    expGrants = "DDDDIDDDDI";
    gotGrants = "";
    iDoneCnt  = 0;
    dDoneCnt  = 0;
    bothCnt   = 0;
    prevReq   = 1'b0;
    finished  = 1'b0;
    @(negedge clk);
    bus.i_req  = 1'b1; bus.i_addr = 32'h600;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2100;
    bus.d_wdata = '0; bus.d_wstrb = '0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (cyc != 0) @(negedge clk);
      bus.mem_ack   = bus.mem_req;
      bus.mem_rdata = 32'(cyc);
      bus.i_abort   = bus.d_done;
      @(posedge clk);
      #1;
      if (bus.mem_req && !prevReq) begin
        gotGrants = {gotGrants, (bus.mem_addr == 32'h600) ? "I" : "D"};
      end
      if (bus.i_done) iDoneCnt++;
      if (bus.d_done) dDoneCnt++;
      if (bus.i_done && bus.d_done) bothCnt++;
      prevReq = bus.mem_req;
      if (gotGrants.len() >= expGrants.len()) finished = 1'b1;
    end
    check("starve.grant_count", 32'(gotGrants.len()), 32'(expGrants.len()));
    for (int g = 0; g < expGrants.len(); g++) begin
      if (g < gotGrants.len())
        check($sformatf("starve.grant%0d", g), 32'(gotGrants[g]), 32'(expGrants[g]));
    end
    check("starve.i_done_count", 32'(iDoneCnt), 32'd1);
    check("starve.d_done_count", 32'(dDoneCnt), 32'd8);
    check("starve.both_done",    32'(bothCnt),  32'd0);

    @(negedge clk);
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.i_abort = 1'b0;
    bus.mem_ack = bus.mem_req;
    @(posedge clk);
    #1;
    check("starve.final_i_done", 32'(bus.i_done), 32'd1);
    check("starve.final_mem_req", 32'(bus.mem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
